dadda_approx_mult_pipe: RTL
===========================

// Module: dadda_approx_mult_pipe
// PURPOSE
//  Parametrised, 3-stage pipelined Dadda-style unsigned multiplier with run-time exact/approximate mode.
//  Successor to the fixed 8-bit combinational compressor multipliers.
//  Adds generic WIDTH, a configurable approximate low-column region and a valid/ready stream interface.
//  Sits between operand sources and accumulators in approximate-computing datapaths.
// PARAMETERS
//  WIDTH        8  operand width in bits (unsigned); legal range 2..32
//  APPROX_COLS  8  number of low product columns approximated in approx mode; legal 0..2*WIDTH-1
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        synchronous active-low reset
//  in_valid   in   1        operand pair valid
//  in_ready   out  1        block accepts operands this cycle
//  in_a       in   WIDTH    multiplicand, unsigned
//  in_b       in   WIDTH    multiplier, unsigned
//  in_mode    in   1        0 = exact product, 1 = approximate product
//  out_valid  out  1        result valid
//  out_ready  in   1        downstream accepts result
//  out_p      out  2*WIDTH  product
//  out_mode   out  1        mode the result was computed with
// BEHAVIOUR
//  Reset (rst_n low at a clk edge):
//   - all stage valid bits, out_valid, out_p and out_mode clear to 0
//   - in_ready is 0 while rst_n is low
//   - an in-flight transaction is discarded, never emitted
//  Pipeline: S1 partial-product generation, S2 column reduction, S3 final carry-propagate add. Registered at each stage.
//  Advance enable: en = !out_valid | out_ready; in_ready = en & rst_n.
//   - Whole pipeline shifts when en is high; holds all stage registers when en is low.
//  Transfer rules:
//   - input accepted on in_valid & in_ready
//   - output consumed on out_valid & out_ready
//   - out_p/out_mode stable while out_valid & !out_ready
//  Latency: a transaction accepted at edge N appears with out_valid=1 after edge N+3, provided out_ready stays 1.
//   - Throughput 1/cycle.
//   - Bubbles are not collapsed; they travel through the stages.
//  in_mode is captured with its operands and travels with them; per-transaction mode switching allowed back-to-back.
//  Arithmetic: pp(i,j) = in_a[i] & in_b[j] lies in column c = i+j.
//   - Exact mode: out_p = in_a * in_b.
//   - Approx mode, for each column c < APPROX_COLS: bit c = OR of all pp in column c. No carry leaves these columns. Columns below APPROX_COLS receive nothing from other columns.
//   - Approx mode, columns c >= APPROX_COLS: all pp summed exactly, with full carry propagation among these columns.
//   - out_p = sum_{c>=K} pp_c*2^c + sum_{c<K} OR(col c)*2^c, where K = APPROX_COLS.
//   - Result always fits in 2*WIDTH bits; no overflow.
//   - APPROX_COLS = 0 makes approx mode identical to exact mode.
//  Simultaneous accept and emit in one cycle is legal when out_ready=1 (full throughput).
//  Reduction tree structure (4:2 compressors, FA, HA) is an implementation choice.
//   - Only the arithmetic above is normative.
// TESTING (WIDTH=8, APPROX_COLS=8 unless noted)
//  1. Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, out_p=0, in_ready=0. After release, in_ready=1.
//  2. Exact: a=255, b=255, mode=0 -> out_p=65025, out_mode=0, 3 cycles after accept. Then a=3, b=3 -> 9.
//  3. Approx: a=3, b=3, mode=1 -> out_p=7. Then a=255, b=255, mode=1 -> out_p=63487, out_mode=1.
//  4. Stream of 4 alternating-mode pairs with out_ready=1 -> 4 results on consecutive cycles, in order, with correct modes.
//  5. Backpressure: out_ready=0 for 5 cycles while out_valid=1 -> out_p held, in_ready=0, no loss or duplication.
//     After release, full order is kept.
//  6. Reset mid-stream with 3 transactions in flight -> none emitted. APPROX_COLS=0 build: random 10k pairs, approx result == a*b.

Source files
------------

// File: rtl/dadda_approx_mult_pipe.sv
// Pipelined unsigned multiplier with a run-time approximate mode: the low APPROX_COLS
// product columns collapse to the OR of their partial products, and the rest are summed exactly.
module dadda_approx_mult_pipe #(
  parameter int WIDTH       = 8,
  parameter int APPROX_COLS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               out_mode
);

  localparam int PW = 2 * WIDTH;
  localparam logic [PW-1:0] ONE     = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] HI_MASK = ~((ONE << APPROX_COLS) - ONE);

  logic en;

  // Operand capture stage
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             mode0_reg, v0_reg;

  // Partial-product stage: one shifted row per multiplier bit
  logic [PW-1:0] rows_next [WIDTH];
  logic [PW-1:0] rows_reg  [WIDTH];
  logic          mode1_reg, v1_reg;

  // Reduction stage: redundant sum/carry pair
  logic [PW-1:0] sum_next, carry_next;
  logic [PW-1:0] sum_reg, carry_reg;
  logic          mode2_reg, v2_reg;

  // Output stage
  logic [PW-1:0] out_p_reg;
  logic          out_mode_reg, out_valid_reg;

  logic [PW-1:0] csa_s, csa_c, csa_t, hi_row, low_or;

  assign en        = !out_valid_reg | out_ready;
  assign in_ready  = en & rst_n;
  assign out_valid = out_valid_reg;
  assign out_p     = out_p_reg;
  assign out_mode  = out_mode_reg;

  // Row j holds pp(i,j) at column i+j
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rows
      assign rows_next[gi] = b_reg[gi] ? ({{WIDTH{1'b0}}, a_reg} << gi) : '0;
    end
  endgenerate

  // Carry-save reduction of the rows. In approx mode the low columns are stripped from
  // the adder inputs, so no carry can originate there, and are replaced by their OR.
  always_comb begin
    csa_s  = '0;
    csa_c  = '0;
    csa_t  = '0;
    hi_row = '0;
    low_or = '0;
    for (int r = 0; r < WIDTH; r++) begin
      hi_row = mode1_reg ? (rows_reg[r] & HI_MASK) : rows_reg[r];
      if (mode1_reg) begin
        low_or = low_or | (rows_reg[r] & ~HI_MASK);
      end
      csa_t = csa_s ^ csa_c ^ hi_row;
      csa_c = ((csa_s & csa_c) | (csa_s & hi_row) | (csa_c & hi_row)) << 1;
      csa_s = csa_t;
    end
    // sum/carry are zero below the approximate boundary, so OR merges the low field cleanly
    sum_next   = csa_s | low_or;
    carry_next = csa_c;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg         <= '0;
      b_reg         <= '0;
      mode0_reg     <= 1'b0;
      v0_reg        <= 1'b0;
      for (int r = 0; r < WIDTH; r++) begin
        rows_reg[r] <= '0;
      end
      mode1_reg     <= 1'b0;
      v1_reg        <= 1'b0;
      sum_reg       <= '0;
      carry_reg     <= '0;
      mode2_reg     <= 1'b0;
      v2_reg        <= 1'b0;
      out_p_reg     <= '0;
      out_mode_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else if (en) begin
      a_reg         <= in_a;
      b_reg         <= in_b;
      mode0_reg     <= in_mode;
      v0_reg        <= in_valid;
      for (int r = 0; r < WIDTH; r++) begin
        rows_reg[r] <= rows_next[r];
      end
      mode1_reg     <= mode0_reg;
      v1_reg        <= v0_reg;
      sum_reg       <= sum_next;
      carry_reg     <= carry_next;
      mode2_reg     <= mode1_reg;
      v2_reg        <= v1_reg;
      out_p_reg     <= sum_reg + carry_reg;
      out_mode_reg  <= mode2_reg;
      out_valid_reg <= v2_reg;
    end
  end

endmodule
